// File: rtl/nibble_serial_adder.sv
// Purpose: WIDTH-bit a+b+cin computed one nibble per clock through one 4-bit ripple adder.
// Latency: accept in cycle 0 -> out_valid in cycle NIB+1; initiation interval NIB+2.
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE.

module ripple_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             carry_q,  carry_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;

    logic [3:0]       add_sum;
    logic             add_cout;
    logic [WIDTH-1:0] sum_shift;

    ripple_adder_4bit u_add (
        .a    (a_sh_q[3:0]),
        .b    (b_sh_q[3:0]),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Each nibble result enters at the top so nibble 0 ends up in bits [3:0].
    if (WIDTH == 4) begin : g_shift_narrow
        assign sum_shift = add_sum;
    end else begin : g_shift_wide
        assign sum_shift = {add_sum, sum_sh_q[WIDTH-1:4]};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 4;
                b_sh_d   = b_sh_q >> 4;
                sum_sh_d = sum_shift;
                carry_d  = add_cout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
        end
    end

    // Outputs come straight from flops; out_valid falls with the async reset.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_sh_q;
    assign cout      = carry_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: a 16-bit instance for the handshake
// scenarios and a 4-bit instance for the exhaustive nibble sweep.
module tb_nibble_serial_adder;
    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [15:0] a, b, sum;

    logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4;
    logic [3:0]  a4, b4, sum4;

    int tests_run;
    int tests_failed;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present an operation in the current cycle (cycle 0); returns in cycle 1.
    task automatic start16(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait16(input int start, output int cyc);
        int n;
        n = start;
        while (out_valid !== 1'b1 && n < start + 40) begin
            @(negedge clk);
            n++;
        end
        cyc = (out_valid === 1'b1) ? n : -1;
    endtask

    task automatic release16();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({out_valid, in_ready, cout, sum} !== {1'b0, 1'b1, 1'b0, 16'h0000}) begin
            tests_failed++;
            $display("FAIL reset16 got v=%b r=%b c=%b s=%h want v=0 r=1 c=0 s=0000",
                     out_valid, in_ready, cout, sum);
        end
        tests_run++;
        if ({out_valid4, in_ready4, cout4, sum4} !== {1'b0, 1'b1, 1'b0, 4'h0}) begin
            tests_failed++;
            $display("FAIL reset4 got v=%b r=%b c=%b s=%h want v=0 r=1 c=0 s=0",
                     out_valid4, in_ready4, cout4, sum4);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({out_valid, in_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL post_reset got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_basic();
        int cyc;
        start16(16'h00FF, 16'h0001, 1'b0);
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL run_in_ready got %b want 0", in_ready);
        end
        wait16(1, cyc);
        tests_run++;
        if (cyc != 5) begin
            tests_failed++;
            $display("FAIL basic_latency got %0d want 5", cyc);
        end
        tests_run++;
        if ({cout, sum} !== {1'b0, 16'h0100}) begin
            tests_failed++;
            $display("FAIL basic_sum got c=%b s=%h want c=0 s=0100", cout, sum);
        end
        release16();
        tests_run++;
        if ({out_valid, in_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL basic_release got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_carry_chain();
        int cyc;
        start16(16'hFFFF, 16'h0000, 1'b1);
        wait16(1, cyc);
        tests_run++;
        if (cyc != 5 || {cout, sum} !== {1'b1, 16'h0000}) begin
            tests_failed++;
            $display("FAIL carry_ffff_0_1 got cyc=%0d c=%b s=%h want cyc=5 c=1 s=0000", cyc, cout, sum);
        end
        release16();
        start16(16'hFFFF, 16'hFFFF, 1'b1);
        wait16(1, cyc);
        tests_run++;
        if (cyc != 5 || {cout, sum} !== {1'b1, 16'hFFFF}) begin
            tests_failed++;
            $display("FAIL carry_ffff_ffff_1 got cyc=%0d c=%b s=%h want cyc=5 c=1 s=ffff", cyc, cout, sum);
        end
        release16();
    endtask

    task automatic test_ignore_in_valid();
        int cyc;
        start16(16'h00FF, 16'h0001, 1'b0);
        a = 16'hAAAA; b = 16'h5555; cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait16(2, cyc);
        tests_run++;
        if (cyc != 5 || {cout, sum} !== {1'b0, 16'h0100}) begin
            tests_failed++;
            $display("FAIL ignore_run got cyc=%0d c=%b s=%h want cyc=5 c=0 s=0100", cyc, cout, sum);
        end
        release16();
    endtask

    task automatic test_backpressure();
        int cyc;
        start16(16'h8001, 16'h8002, 1'b0);
        wait16(1, cyc);
        a = 16'h1111; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if ({out_valid, in_ready, cout, sum} !== {1'b1, 1'b0, 1'b1, 16'h0003}) begin
                tests_failed++;
                $display("FAIL hold_%0d got v=%b r=%b c=%b s=%h want v=1 r=0 c=1 s=0003",
                         i, out_valid, in_ready, cout, sum);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        release16();
        tests_run++;
        if ({out_valid, in_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL hold_release got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        start16(16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, in_ready, cout, sum} !== {1'b0, 1'b1, 1'b0, 16'h0000}) begin
            tests_failed++;
            $display("FAIL reset_run got v=%b r=%b c=%b s=%h want v=0 r=1 c=0 s=0000",
                     out_valid, in_ready, cout, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start16(16'h1234, 16'h4321, 1'b0);
        wait16(1, cyc);
        tests_run++;
        if (cyc != 5 || {cout, sum} !== {1'b0, 16'h5555}) begin
            tests_failed++;
            $display("FAIL after_reset got cyc=%0d c=%b s=%h want cyc=5 c=0 s=5555", cyc, cout, sum);
        end
        release16();
    endtask

    task automatic test_reset_mid_done();
        int cyc;
        start16(16'hFFFF, 16'hFFFF, 1'b1);
        wait16(1, cyc);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, cout, sum} !== {1'b0, 1'b0, 16'h0000}) begin
            tests_failed++;
            $display("FAIL reset_done got v=%b c=%b s=%h want v=0 c=0 s=0000", out_valid, cout, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int          n_out;
        int          cyc1, cyc2;
        logic [16:0] res1, res2;
        n_out = 0; cyc1 = -1; cyc2 = -1; res1 = '0; res2 = '0;
        a = 16'h0102; b = 16'h0304; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin
                a = 16'h1000; b = 16'h2000; cin = 1'b1;
            end
            if (c == 7) in_valid = 1'b0;
            if (out_valid === 1'b1) begin
                if (n_out == 0) begin cyc1 = c; res1 = {cout, sum}; end
                else if (n_out == 1) begin cyc2 = c; res2 = {cout, sum}; end
                n_out++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        tests_run++;
        if (n_out != 2 || cyc1 != 5 || res1 !== {1'b0, 16'h0406}) begin
            tests_failed++;
            $display("FAIL b2b_first got n=%0d cyc=%0d res=%h want n=2 cyc=5 res=00406", n_out, cyc1, res1);
        end
        tests_run++;
        if (cyc2 != 11 || res2 !== {1'b0, 16'h3001}) begin
            tests_failed++;
            $display("FAIL b2b_second got cyc=%0d res=%h want cyc=11 res=03001", cyc2, res2);
        end
        @(negedge clk);
    endtask

    task automatic test_width4_sweep();
        int         n;
        logic [4:0] exp4;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    exp4 = 5'(ai + bi + ci);
                    a4 = 4'(ai); b4 = 4'(bi); cin4 = ci[0]; in_valid4 = 1'b1;
                    @(negedge clk);
                    in_valid4 = 1'b0;
                    n = 1;
                    while (out_valid4 !== 1'b1 && n < 20) begin
                        @(negedge clk);
                        n++;
                    end
                    tests_run++;
                    if (out_valid4 !== 1'b1 || n != 2 || {cout4, sum4} !== exp4) begin
                        tests_failed++;
                        $display("FAIL sweep4 a=%0d b=%0d cin=%0d got v=%b cyc=%0d res=%0d want cyc=2 res=%0d",
                                 ai, bi, ci, out_valid4, n, {cout4, sum4}, exp4);
                    end
                    out_ready4 = 1'b1;
                    @(negedge clk);
                    out_ready4 = 1'b0;
                end
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_carry_chain();
        test_ignore_in_valid();
        test_backpressure();
        test_reset_mid_run();
        test_reset_mid_done();
        test_back_to_back();
        test_width4_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
